// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: req/ack bus between the data-memory controller and a
// variable-latency data memory.
//   MemReq   : access request, held high until MemAck or timeout
//   MemWe    : 1 = write, 0 = read (valid with MemReq)
//   MemAddr  : word address (valid with MemReq)
//   MemWData : store data (valid with MemReq)
//   MemAck   : one-cycle completion pulse from memory
//   MemRData : load data, valid while MemAck = 1
// master = controller side, slave = memory side.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic              MemAck;
    logic [31:0]       MemRData;

    modport master (output MemReq, MemWe, MemAddr, MemWData,
                    input  MemAck, MemRData);
    modport slave  (input  MemReq, MemWe, MemAddr, MemWData,
                    output MemAck, MemRData);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller behind a single-cycle datapath.
// Turns the datapath's MemRead/MemWrite strobes into one req/ack memory
// transaction, holds the datapath with Stall until it completes, and flags
// bus timeouts. Each access runs IDLE -> BUSY -> DONE; DONE always returns
// to IDLE so a retiring instruction is never issued twice.
//
// Ports:
//   CLK, Reset          : clock (rising edge), synchronous active-high reset
//   MemRead, MemWrite   : load / store strobes (both high = store)
//   Addr, WriteData     : byte address and store data from the datapath
//   ReadData            : load result, holds its value between loads
//   Stall               : hold PC / suppress RegWrite while access in flight
//   BusErr              : high in DONE of an access that timed out
//   Misalign            : high in DONE of a rejected misaligned request
//   AccessCnt           : count of successfully completed accesses (wraps)
//   mem                 : memory bus (dmem_ctrl_if master modport)
//
// Build option: define DMEM_ALIGN_CHECK_EN to reject requests whose
// Addr[1:0] != 0 (no memory access, Misalign pulse in DONE). Without it the
// low address bits are ignored and Misalign is tied low.
module dmem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      Addr,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic             Stall,
    output logic             BusErr,
    output logic             Misalign,
    output logic [CNT_W-1:0] AccessCnt,
    dmem_ctrl_if.master      mem
);
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, nextState;
    logic [TO_W-1:0] toCnt;
    logic            req;
    logic            misReq;   // misaligned request seen in IDLE
    logic            ackHit;   // BUSY cycle that completes with MemAck
    logic            timeOut;  // BUSY cycle that gives up waiting

    assign req = MemRead | MemWrite;

    // Address bits the memory never sees; Addr[1:0] is consumed only by the
    // optional alignment check.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{Addr[31:ADDR_W+2], Addr[1:0]};

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        misReq    = 1'b0;
        ackHit    = 1'b0;
        timeOut   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    Stall = 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                    misReq    = (Addr[1:0] != 2'b00);
                    nextState = misReq ? DONE : BUSY;
`else
                    nextState = BUSY;
`endif
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mem.MemAck) begin
                    ackHit    = 1'b1;
                    nextState = DONE;
                end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
                    timeOut   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request is a pure function of state, so it drops the cycle after
    // ack/timeout and is low immediately after reset.
    assign mem.MemReq = (state == BUSY);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem.MemWe    <= 1'b0;
            mem.MemAddr  <= '0;
            mem.MemWData <= '0;
            ReadData     <= '0;
            BusErr       <= 1'b0;
            AccessCnt    <= '0;
            toCnt        <= '0;
        end else begin
            // Latch the request only when leaving IDLE for BUSY; the bus
            // fields then stay stable for the whole BUSY phase.
            if (state == IDLE && req && !misReq) begin
                mem.MemWe    <= MemWrite;
                mem.MemAddr  <= Addr[ADDR_W+1:2];
                mem.MemWData <= WriteData;
                toCnt        <= '0;
            end else if (state == BUSY) begin
                toCnt <= toCnt + 1'b1;
            end
            if (ackHit) begin
                if (!mem.MemWe) ReadData <= mem.MemRData;
                AccessCnt <= AccessCnt + 1'b1;
            end
            if (timeOut) ReadData <= '0;
            BusErr <= timeOut;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (Reset) Misalign <= 1'b0;
        else       Misalign <= misReq;
    end
`else
    assign Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (TIMEOUT = 8, CNT_W = 2).
module tb_dmem_ctrl;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 2;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             MemRead, MemWrite;
    logic [31:0]      Addr, WriteData;
    logic [31:0]      ReadData;
    logic             Stall, BusErr, Misalign;
    logic [CNT_W-1:0] AccessCnt;

    int tests = 0;
    int fails = 0;

    dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .Misalign  (Misalign),
        .AccessCnt (AccessCnt),
        .mem       (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access acked in its first BUSY cycle; leaves the bench in the
    // DONE cycle's following IDLE with the strobes still applied.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [31:0] expRd,
                          input logic [31:0] expCnt, input string tag);
        MemRead = !we; MemWrite = we; Addr = a; WriteData = wd;
        #1 chk({tag, " stall idle"}, Stall, 1);
        tick();
        chk({tag, " req"}, bus.MemReq, 1);
        chk({tag, " addr"}, bus.MemAddr, a[ADDR_W+1:2]);
        chk({tag, " we"}, bus.MemWe, we);
        bus.MemAck = 1'b1; bus.MemRData = rd;
        tick();
        bus.MemAck = 1'b0;
        chk({tag, " done stall"}, Stall, 0);
        chk({tag, " done req"}, bus.MemReq, 0);
        chk({tag, " rdata"}, ReadData, expRd);
        chk({tag, " cnt"}, AccessCnt, expCnt);
        tick();
    endtask

    initial begin
        int n;
        Reset = 1'b1; MemRead = 0; MemWrite = 0; Addr = 0; WriteData = 0;
        bus.MemAck = 0; bus.MemRData = 0;
        tick(); tick();
        chk("rst req", bus.MemReq, 0);
        chk("rst we", bus.MemWe, 0);
        chk("rst addr", bus.MemAddr, 0);
        chk("rst wdata", bus.MemWData, 0);
        chk("rst rdata", ReadData, 0);
        chk("rst buserr", BusErr, 0);
        chk("rst misalign", Misalign, 0);
        chk("rst cnt", AccessCnt, 0);
        chk("rst stall", Stall, 0);
        Reset = 1'b0;
        tick();

        // Read 0x10, immediate ack: Stall high in IDLE and one BUSY cycle.
        MemRead = 1; Addr = 32'h10;
        #1 chk("rd1 stall idle", Stall, 1);
        tick();
        chk("rd1 stall busy", Stall, 1);
        chk("rd1 req", bus.MemReq, 1);
        chk("rd1 addr", bus.MemAddr, 16'h0004);
        chk("rd1 we", bus.MemWe, 0);
        bus.MemAck = 1; bus.MemRData = 32'h1234_5678;
        tick();
        bus.MemAck = 0;
        chk("rd1 done stall", Stall, 0);
        chk("rd1 done req", bus.MemReq, 0);
        chk("rd1 rdata", ReadData, 32'h1234_5678);
        chk("rd1 cnt", AccessCnt, 1);
        MemRead = 0;
        tick();
        chk("rd1 idle stall", Stall, 0);

        // Write 0x20 with ack in the 6th BUSY cycle.
        MemWrite = 1; Addr = 32'h20; WriteData = 32'hCAFE_F00D;
        tick();
        for (int k = 1; k <= 6; k++) begin
            chk("wr req", bus.MemReq, 1);
            chk("wr we", bus.MemWe, 1);
            chk("wr addr", bus.MemAddr, 16'h0008);
            chk("wr wdata", bus.MemWData, 32'hCAFE_F00D);
            if (k == 6) bus.MemAck = 1;
            tick();
        end
        bus.MemAck = 0;
        chk("wr done stall", Stall, 0);
        chk("wr done req", bus.MemReq, 0);
        chk("wr rdata kept", ReadData, 32'h1234_5678);
        chk("wr cnt", AccessCnt, 2);
        MemWrite = 0;
        tick();

        // Read with no ack: timeout after 8 BUSY cycles.
        MemRead = 1; Addr = 32'h30;
        tick();
        n = 0;
        while (bus.MemReq === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("to busy cycles", n, 8);
        chk("to buserr", BusErr, 1);
        chk("to rdata", ReadData, 0);
        chk("to cnt", AccessCnt, 2);
        chk("to stall", Stall, 0);
        MemRead = 0;
        bus.MemAck = 1; bus.MemRData = 32'hDEAD_BEEF;  // stray ack in DONE
        tick();
        bus.MemAck = 0;
        chk("to buserr clr", BusErr, 0);
        chk("stray ack rdata", ReadData, 0);
        chk("stray ack cnt", AccessCnt, 2);
        chk("stray ack req", bus.MemReq, 0);

        // Reset in the 3rd BUSY cycle, ack right after.
        MemRead = 1; Addr = 32'h40;
        tick(); tick(); tick();
        chk("rst3 busy", bus.MemReq, 1);
        Reset = 1;
        tick();
        Reset = 0; MemRead = 0;
        bus.MemAck = 1; bus.MemRData = 32'h5555_AAAA;
        #1 chk("rst3 req", bus.MemReq, 0);
        chk("rst3 stall", Stall, 0);
        chk("rst3 cnt", AccessCnt, 0);
        tick();
        bus.MemAck = 0;
        chk("late ack req", bus.MemReq, 0);
        chk("late ack rdata", ReadData, 0);
        chk("late ack cnt", AccessCnt, 0);

        // Back-to-back load then store, then count wrap with CNT_W = 2.
        access(0, 32'h50, 32'h0, 32'hA5A5_0001, 32'hA5A5_0001, 1, "b2b ld");
        access(1, 32'h54, 32'h1111_2222, 32'hFFFF_FFFF, 32'hA5A5_0001, 2, "b2b st");
        MemWrite = 0;
        #1 chk("no reissue stall", Stall, 0);
        tick();
        chk("no reissue req", bus.MemReq, 0);
        access(0, 32'h60, 32'h0, 32'h0000_0003, 32'h0000_0003, 3, "wrap1");
        access(1, 32'h64, 32'h7, 32'h0, 32'h0000_0003, 0, "wrap2");
        access(0, 32'h68, 32'h0, 32'h0000_0005, 32'h0000_0005, 1, "wrap3");
        access(0, 32'h6C, 32'h0, 32'h0000_0006, 32'h0000_0006, 2, "wrap4");
        MemRead = 0; MemWrite = 0;
        tick();

        // Misaligned read at 0x13.
        MemRead = 1; Addr = 32'h13;
        #1 chk("mis stall idle", Stall, 1);
        tick();
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis req", bus.MemReq, 0);
        chk("mis stall done", Stall, 0);
        chk("mis flag", Misalign, 1);
        chk("mis cnt", AccessCnt, 2);
        chk("mis rdata", ReadData, 32'h0000_0006);
        MemRead = 0;
        tick();
        chk("mis flag clr", Misalign, 0);
        chk("mis req idle", bus.MemReq, 0);
`else
        chk("mis req", bus.MemReq, 1);
        chk("mis addr", bus.MemAddr, 16'h0004);
        bus.MemAck = 1; bus.MemRData = 32'h0BAD_F00D;
        tick();
        bus.MemAck = 0;
        chk("mis flag", Misalign, 0);
        chk("mis rdata", ReadData, 32'h0BAD_F00D);
        chk("mis cnt", AccessCnt, 3);
        MemRead = 0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller directly downstream of the single-cycle datapath.
- Consumes the datapath's ALU address, store data and memory-enable strobes, and returns load data.
- Drives a req/ack handshake to a variable-latency data memory.
- Asserts Stall so the PC register and register-file write hold until the access completes; includes a bus timeout and an access counter.

Parameters:
- ADDR_W, 16: word-address width on the memory side; MemAddr = Addr[ADDR_W+1:2].
- TIMEOUT, 64: maximum BUSY cycles waiting for MemAck before a bus error; legal range 2..1024.
- CNT_W, 16: width of the completed-access counter.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  synchronous active-high reset.
- MemRead  input  1  load request for the current instruction.
- MemWrite  input  1  store request for the current instruction.
- Addr  input  32  byte address (datapath AluOut).
- WriteData  input  32  store data.
- ReadData  output  32  load data to the datapath result mux.
- Stall  output  1  high: datapath must hold PC and suppress RegWrite.
- BusErr  output  1  high for the DONE cycle of a timed-out access.
- Misalign  output  1  high for the DONE cycle of a misaligned request (optional feature).
- AccessCnt  output  CNT_W  count of successfully completed accesses.
- MemReq  output  1  request to memory.
- MemWe  output  1  1 = write, 0 = read; valid with MemReq.
- MemAddr  output  ADDR_W  word address; valid with MemReq.
- MemWData  output  32  write data; valid with MemReq.
- MemAck  input  1  memory completion; one-cycle pulse.
- MemRData  input  32  read data; valid when MemAck = 1.

Behaviour:
- Single clock CLK; Reset synchronous, active-high. Reset wins over all other events.
- Reset values: state IDLE; ReadData 0; MemReq 0; MemWe 0; MemAddr 0; MemWData 0; BusErr 0; Misalign 0; AccessCnt 0; timeout counter 0.
- States: IDLE, BUSY, DONE.
- IDLE, req = MemRead | MemWrite:
  - If req = 1, register MemAddr, MemWData and MemWe (MemWe = MemWrite), then go to BUSY.
  - If MemRead and MemWrite are both 1, treat as write.
- BUSY:
  - MemReq = 1; MemWe, MemAddr and MemWData are held stable.
  - Timeout counter increments each cycle.
  - On MemAck: if read, capture MemRData into ReadData; increment AccessCnt (wraps modulo 2^CNT_W); go to DONE.
  - If the counter reaches TIMEOUT-1 without MemAck: BusErr = 1 in DONE, ReadData = 0, AccessCnt not incremented; go to DONE.
- DONE:
  - MemReq = 0; Stall = 0; ReadData valid.
  - The instruction retires at the end of this cycle.
  - Unconditionally go to IDLE, so the same instruction is never re-issued.
- Stall (combinational) = (IDLE & req) | BUSY. Stall is 0 in DONE and in IDLE with no request.
- Minimum access latency: 3 cycles (IDLE, BUSY with immediate ack, DONE). Each additional ack wait adds one cycle.
- MemReq is asserted from the cycle after the request is detected. It drops in the cycle after MemAck or after timeout.
- MemAck seen in IDLE or DONE is ignored: no state change, no capture.
- ReadData holds its last value across writes and idle cycles.
- Reset during BUSY: next cycle is IDLE with MemReq = 0. A late MemAck is then ignored.
- Timeout counter is cleared on entry to BUSY.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - An IDLE request with Addr[1:0] != 0 issues no memory request and goes directly to DONE (Stall high for exactly that IDLE cycle).
  - In DONE, Misalign = 1; ReadData is unchanged and AccessCnt is not incremented.
- Undefined:
  - Addr[1:0] is ignored.
  - Misalign is tied to 0.

Test Plan:
- Reset, then a read at Addr = 0x0000_0010 with MemAck one cycle after MemReq and MemRData = 0x1234_5678:
  - MemAddr = 0x0004, MemWe = 0.
  - Stall is high for 2 cycles.
  - ReadData = 0x1234_5678 in DONE; AccessCnt = 1.
- Write Addr = 0x0000_0020, WriteData = 0xCAFE_F00D, with ack delayed 5 cycles:
  - MemReq high 6 cycles with MemWe = 1, MemAddr = 0x0008, MemWData stable.
  - Stall low in DONE; ReadData unchanged.
- Read with no MemAck and TIMEOUT = 8:
  - MemReq drops after 8 BUSY cycles.
  - BusErr = 1 for one cycle; ReadData = 0; AccessCnt unchanged.
- Reset asserted in the 3rd BUSY cycle, and MemAck pulsed the next cycle:
  - State is IDLE; MemReq = 0.
  - ReadData = 0, AccessCnt = 0; the ack is ignored.
- Back-to-back load then store (each acked immediately):
  - Each access takes 3 cycles and the store is not re-issued.
  - AccessCnt goes 0→1→2. With CNT_W = 2, 4 more accesses wrap the count to 2.
- With DMEM_ALIGN_CHECK_EN, read Addr = 0x0000_0013:
  - MemReq stays 0.
  - Stall is high 1 cycle, then Misalign = 1 for one cycle; AccessCnt unchanged.
  - Without the macro: a normal access occurs with MemAddr = 0x0004.
